// File: rtl/result_bus_pipe.sv
// result_bus_pipe
//
// Producer side of the hazard bus. Tracks the destination descriptors of the
// instructions in EX, MEM and WB. Publishes the EX_* / MEM_* sets that the
// forwarder compares against ID-stage sources, and drives the register-file
// and HI/LO write port from WB.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   stall                      load-use stall; inserts a bubble into EX
//   flush                      kills ID->EX and EX->MEM (taken branch/exception)
//   id_*                       ID-stage instruction descriptor
//   ex_alu_data/hi_in/lo_in    combinational EX results of the EX instruction
//   mem_load_data              load result of the MEM instruction
//   EX_*                       EX-stage descriptor and result data
//   MEM_*                      MEM-stage descriptor and result data
//   wb_*                       register-file and HI/LO write port
//   stall_cnt                  saturating count of stall bubbles
//
// Build option: define HILO_TRACK_EN to carry HI/LO enables and data through
// the pipe. Without it every HI/LO output is tied to 0.
module result_bus_pipe #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [5:0]    id_op,
  input  logic [5:0]    id_func,
  input  logic [RW-1:0] id_rdc,
  input  logic          id_rd_wena,
  input  logic          id_hi_wena,
  input  logic          id_lo_wena,
  input  logic [DW-1:0] ex_alu_data,
  input  logic [DW-1:0] ex_hi_in,
  input  logic [DW-1:0] ex_lo_in,
  input  logic [DW-1:0] mem_load_data,
  output logic [5:0]    EX_op,
  output logic [5:0]    EX_func,
  output logic [RW-1:0] EX_rdc,
  output logic          EX_rd_wena,
  output logic          EX_hi_wena,
  output logic          EX_lo_wena,
  output logic [DW-1:0] EX_rd_data,
  output logic [DW-1:0] EX_hi_data,
  output logic [DW-1:0] EX_lo_data,
  output logic [RW-1:0] MEM_rdc,
  output logic          MEM_rd_wena,
  output logic          MEM_hi_wena,
  output logic          MEM_lo_wena,
  output logic [DW-1:0] MEM_rd_data,
  output logic [DW-1:0] MEM_hi_data,
  output logic [DW-1:0] MEM_lo_data,
  output logic [RW-1:0] wb_rdc,
  output logic          wb_rd_wena,
  output logic [DW-1:0] wb_rd_data,
  output logic          wb_hi_wena,
  output logic [DW-1:0] wb_hi_data,
  output logic          wb_lo_wena,
  output logic [DW-1:0] wb_lo_data,
  output logic [15:0]   stall_cnt
);

  // Load opcodes (MIPS encoding)
  localparam logic [5:0] LwOp  = 6'b100011;
  localparam logic [5:0] LhOp  = 6'b100001;
  localparam logic [5:0] LhuOp = 6'b100101;
  localparam logic [5:0] LbOp  = 6'b100000;
  localparam logic [5:0] LbuOp = 6'b100100;

  logic          ex_valid_q, ex_valid_d;
  logic [5:0]    ex_op_q, ex_op_d;
  logic [5:0]    ex_func_q, ex_func_d;
  logic [RW-1:0] ex_rdc_q, ex_rdc_d;
  logic          ex_rd_wena_q, ex_rd_wena_d;
  logic          ex_is_load_q, ex_is_load_d;

  logic          mem_valid_q, mem_valid_d;
  logic [RW-1:0] mem_rdc_q, mem_rdc_d;
  logic          mem_rd_wena_q, mem_rd_wena_d;
  logic          mem_is_load_q, mem_is_load_d;
  logic [DW-1:0] mem_alu_q, mem_alu_d;

  logic [RW-1:0] wb_rdc_q, wb_rdc_d;
  logic          wb_rd_wena_q, wb_rd_wena_d;
  logic [DW-1:0] wb_rd_data_q, wb_rd_data_d;

  logic [15:0]   stall_cnt_q, stall_cnt_d;
  logic          id_is_load;

  assign id_is_load = (id_op == LwOp) || (id_op == LhOp) || (id_op == LhuOp) ||
                      (id_op == LbOp) || (id_op == LbuOp);

  always_comb begin
    // WB always receives the old MEM contents, enables already gated by valid
    wb_rdc_d      = mem_rdc_q;
    wb_rd_wena_d  = MEM_rd_wena;
    wb_rd_data_d  = MEM_rd_data;
    // Bubble defaults for EX and MEM
    ex_valid_d    = 1'b0;
    ex_op_d       = '0;
    ex_func_d     = '0;
    ex_rdc_d      = '0;
    ex_rd_wena_d  = 1'b0;
    ex_is_load_d  = 1'b0;
    mem_valid_d   = 1'b0;
    mem_rdc_d     = '0;
    mem_rd_wena_d = 1'b0;
    mem_is_load_d = 1'b0;
    mem_alu_d     = '0;
    stall_cnt_d   = stall_cnt_q;
    if (!flush) begin
      mem_valid_d   = ex_valid_q;
      mem_rdc_d     = ex_rdc_q;
      mem_rd_wena_d = ex_rd_wena_q;
      mem_is_load_d = ex_is_load_q;
      mem_alu_d     = ex_alu_data;
      if (stall) begin
        if (stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
      end else begin
        ex_valid_d   = id_valid;
        ex_op_d      = id_op;
        ex_func_d    = id_func;
        ex_rdc_d     = id_rdc;
        // $0 is never written nor forwarded
        ex_rd_wena_d = id_rd_wena && (id_rdc != '0);
        ex_is_load_d = id_is_load;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q    <= 1'b0;
      ex_op_q       <= '0;
      ex_func_q     <= '0;
      ex_rdc_q      <= '0;
      ex_rd_wena_q  <= 1'b0;
      ex_is_load_q  <= 1'b0;
      mem_valid_q   <= 1'b0;
      mem_rdc_q     <= '0;
      mem_rd_wena_q <= 1'b0;
      mem_is_load_q <= 1'b0;
      mem_alu_q     <= '0;
      wb_rdc_q      <= '0;
      wb_rd_wena_q  <= 1'b0;
      wb_rd_data_q  <= '0;
      stall_cnt_q   <= '0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_op_q       <= ex_op_d;
      ex_func_q     <= ex_func_d;
      ex_rdc_q      <= ex_rdc_d;
      ex_rd_wena_q  <= ex_rd_wena_d;
      ex_is_load_q  <= ex_is_load_d;
      mem_valid_q   <= mem_valid_d;
      mem_rdc_q     <= mem_rdc_d;
      mem_rd_wena_q <= mem_rd_wena_d;
      mem_is_load_q <= mem_is_load_d;
      mem_alu_q     <= mem_alu_d;
      wb_rdc_q      <= wb_rdc_d;
      wb_rd_wena_q  <= wb_rd_wena_d;
      wb_rd_data_q  <= wb_rd_data_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign EX_op       = ex_op_q;
  assign EX_func     = ex_func_q;
  assign EX_rdc      = ex_rdc_q;
  assign EX_rd_wena  = ex_valid_q & ex_rd_wena_q;
  assign EX_rd_data  = ex_alu_data;
  assign MEM_rdc     = mem_rdc_q;
  assign MEM_rd_wena = mem_valid_q & mem_rd_wena_q;
  // Load data is substituted combinationally so it can be forwarded this cycle
  assign MEM_rd_data = mem_is_load_q ? mem_load_data : mem_alu_q;
  assign wb_rdc      = wb_rdc_q;
  assign wb_rd_wena  = wb_rd_wena_q;
  assign wb_rd_data  = wb_rd_data_q;
  assign stall_cnt   = stall_cnt_q;

`ifdef HILO_TRACK_EN
  logic          ex_hi_wena_q, ex_hi_wena_d, ex_lo_wena_q, ex_lo_wena_d;
  logic          mem_hi_wena_q, mem_hi_wena_d, mem_lo_wena_q, mem_lo_wena_d;
  logic [DW-1:0] mem_hi_q, mem_hi_d, mem_lo_q, mem_lo_d;
  logic          wb_hi_wena_q, wb_hi_wena_d, wb_lo_wena_q, wb_lo_wena_d;
  logic [DW-1:0] wb_hi_data_q, wb_hi_data_d, wb_lo_data_q, wb_lo_data_d;

  always_comb begin
    wb_hi_wena_d  = MEM_hi_wena;
    wb_lo_wena_d  = MEM_lo_wena;
    wb_hi_data_d  = mem_hi_q;
    wb_lo_data_d  = mem_lo_q;
    ex_hi_wena_d  = 1'b0;
    ex_lo_wena_d  = 1'b0;
    mem_hi_wena_d = 1'b0;
    mem_lo_wena_d = 1'b0;
    mem_hi_d      = '0;
    mem_lo_d      = '0;
    if (!flush) begin
      mem_hi_wena_d = ex_hi_wena_q;
      mem_lo_wena_d = ex_lo_wena_q;
      mem_hi_d      = ex_hi_in;
      mem_lo_d      = ex_lo_in;
      if (!stall) begin
        ex_hi_wena_d = id_hi_wena;
        ex_lo_wena_d = id_lo_wena;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_hi_wena_q  <= 1'b0;
      ex_lo_wena_q  <= 1'b0;
      mem_hi_wena_q <= 1'b0;
      mem_lo_wena_q <= 1'b0;
      mem_hi_q      <= '0;
      mem_lo_q      <= '0;
      wb_hi_wena_q  <= 1'b0;
      wb_lo_wena_q  <= 1'b0;
      wb_hi_data_q  <= '0;
      wb_lo_data_q  <= '0;
    end else begin
      ex_hi_wena_q  <= ex_hi_wena_d;
      ex_lo_wena_q  <= ex_lo_wena_d;
      mem_hi_wena_q <= mem_hi_wena_d;
      mem_lo_wena_q <= mem_lo_wena_d;
      mem_hi_q      <= mem_hi_d;
      mem_lo_q      <= mem_lo_d;
      wb_hi_wena_q  <= wb_hi_wena_d;
      wb_lo_wena_q  <= wb_lo_wena_d;
      wb_hi_data_q  <= wb_hi_data_d;
      wb_lo_data_q  <= wb_lo_data_d;
    end
  end

  assign EX_hi_wena  = ex_valid_q & ex_hi_wena_q;
  assign EX_lo_wena  = ex_valid_q & ex_lo_wena_q;
  assign EX_hi_data  = ex_hi_in;
  assign EX_lo_data  = ex_lo_in;
  assign MEM_hi_wena = mem_valid_q & mem_hi_wena_q;
  assign MEM_lo_wena = mem_valid_q & mem_lo_wena_q;
  assign MEM_hi_data = mem_hi_q;
  assign MEM_lo_data = mem_lo_q;
  assign wb_hi_wena  = wb_hi_wena_q;
  assign wb_lo_wena  = wb_lo_wena_q;
  assign wb_hi_data  = wb_hi_data_q;
  assign wb_lo_data  = wb_lo_data_q;
`else
  logic unused_hilo;
  assign unused_hilo = ^{id_hi_wena, id_lo_wena, ex_hi_in, ex_lo_in};

  assign EX_hi_wena  = 1'b0;
  assign EX_lo_wena  = 1'b0;
  assign EX_hi_data  = '0;
  assign EX_lo_data  = '0;
  assign MEM_hi_wena = 1'b0;
  assign MEM_lo_wena = 1'b0;
  assign MEM_hi_data = '0;
  assign MEM_lo_data = '0;
  assign wb_hi_wena  = 1'b0;
  assign wb_lo_wena  = 1'b0;
  assign wb_hi_data  = '0;
  assign wb_lo_data  = '0;
`endif

endmodule

// File: tb/tb_result_bus_pipe.sv
// Testbench for result_bus_pipe: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against an instruction-level model.
module tb_result_bus_pipe;
  localparam int DW = 32;
  localparam int RW = 5;
`ifdef HILO_TRACK_EN
  localparam bit HiloEn = 1'b1;
`else
  localparam bit HiloEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n, stall, flush, id_valid;
  logic [5:0]    id_op, id_func;
  logic [RW-1:0] id_rdc;
  logic          id_rd_wena, id_hi_wena, id_lo_wena;
  logic [DW-1:0] ex_alu_data, ex_hi_in, ex_lo_in, mem_load_data;
  logic [5:0]    EX_op, EX_func;
  logic [RW-1:0] EX_rdc, MEM_rdc, wb_rdc;
  logic          EX_rd_wena, EX_hi_wena, EX_lo_wena;
  logic          MEM_rd_wena, MEM_hi_wena, MEM_lo_wena;
  logic          wb_rd_wena, wb_hi_wena, wb_lo_wena;
  logic [DW-1:0] EX_rd_data, EX_hi_data, EX_lo_data;
  logic [DW-1:0] MEM_rd_data, MEM_hi_data, MEM_lo_data;
  logic [DW-1:0] wb_rd_data, wb_hi_data, wb_lo_data;
  logic [15:0]   stall_cnt;

  result_bus_pipe #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_op(id_op), .id_func(id_func), .id_rdc(id_rdc),
    .id_rd_wena(id_rd_wena), .id_hi_wena(id_hi_wena), .id_lo_wena(id_lo_wena),
    .ex_alu_data(ex_alu_data), .ex_hi_in(ex_hi_in), .ex_lo_in(ex_lo_in),
    .mem_load_data(mem_load_data),
    .EX_op(EX_op), .EX_func(EX_func), .EX_rdc(EX_rdc),
    .EX_rd_wena(EX_rd_wena), .EX_hi_wena(EX_hi_wena), .EX_lo_wena(EX_lo_wena),
    .EX_rd_data(EX_rd_data), .EX_hi_data(EX_hi_data), .EX_lo_data(EX_lo_data),
    .MEM_rdc(MEM_rdc), .MEM_rd_wena(MEM_rd_wena), .MEM_hi_wena(MEM_hi_wena),
    .MEM_lo_wena(MEM_lo_wena), .MEM_rd_data(MEM_rd_data), .MEM_hi_data(MEM_hi_data),
    .MEM_lo_data(MEM_lo_data),
    .wb_rdc(wb_rdc), .wb_rd_wena(wb_rd_wena), .wb_rd_data(wb_rd_data),
    .wb_hi_wena(wb_hi_wena), .wb_hi_data(wb_hi_data), .wb_lo_wena(wb_lo_wena),
    .wb_lo_data(wb_lo_data), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction-level model: one record per stage, results captured when produced
  typedef struct {
    bit        v;
    bit [5:0]  op;
    bit [5:0]  func;
    bit [4:0]  rd;
    bit        rw, hw, lw;
    bit [31:0] alu, hi, lo, res;
  } ins_t;

  ins_t m_ex, m_mem, m_wb, bub;
  int   m_cnt;

  function automatic bit is_load(input bit [5:0] op);
    return op inside {6'h23, 6'h21, 6'h25, 6'h20, 6'h24};
  endfunction

  function automatic bit writes_rd(input ins_t i);
    return i.v && i.rw && (i.rd != 5'd0);
  endfunction

  task automatic model_reset();
    bub   = '{default: 0};
    m_ex  = bub;
    m_mem = bub;
    m_wb  = bub;
    m_cnt = 0;
  endtask

  task automatic model_clock();
    ins_t old_ex, old_mem;
    old_ex   = m_ex;
    old_mem  = m_mem;
    m_wb     = old_mem;
    m_wb.res = is_load(old_mem.op) ? mem_load_data : old_mem.alu;
    if (flush) begin
      m_ex  = bub;
      m_mem = bub;
    end else begin
      m_mem     = old_ex;
      m_mem.alu = ex_alu_data;
      m_mem.hi  = ex_hi_in;
      m_mem.lo  = ex_lo_in;
      if (stall) begin
        m_ex = bub;
        if (m_cnt < 65535) m_cnt++;
      end else begin
        m_ex      = bub;
        m_ex.v    = id_valid;
        m_ex.op   = id_op;
        m_ex.func = id_func;
        m_ex.rd   = id_rdc;
        m_ex.rw   = id_rd_wena;
        m_ex.hw   = id_hi_wena;
        m_ex.lw   = id_lo_wena;
      end
    end
  endtask

  task automatic check_model();
    chk("EX_op", EX_op, m_ex.op);
    chk("EX_func", EX_func, m_ex.func);
    chk("EX_rdc", EX_rdc, m_ex.rd);
    chk("EX_rd_wena", EX_rd_wena, writes_rd(m_ex));
    chk("EX_hi_wena", EX_hi_wena, HiloEn && m_ex.v && m_ex.hw);
    chk("EX_lo_wena", EX_lo_wena, HiloEn && m_ex.v && m_ex.lw);
    chk("EX_rd_data", EX_rd_data, ex_alu_data);
    chk("EX_hi_data", EX_hi_data, HiloEn ? ex_hi_in : 32'd0);
    chk("EX_lo_data", EX_lo_data, HiloEn ? ex_lo_in : 32'd0);
    chk("MEM_rdc", MEM_rdc, m_mem.rd);
    chk("MEM_rd_wena", MEM_rd_wena, writes_rd(m_mem));
    chk("MEM_hi_wena", MEM_hi_wena, HiloEn && m_mem.v && m_mem.hw);
    chk("MEM_lo_wena", MEM_lo_wena, HiloEn && m_mem.v && m_mem.lw);
    if (writes_rd(m_mem))
      chk("MEM_rd_data", MEM_rd_data, is_load(m_mem.op) ? mem_load_data : m_mem.alu);
    if (!HiloEn || (m_mem.v && m_mem.hw))
      chk("MEM_hi_data", MEM_hi_data, HiloEn ? m_mem.hi : 32'd0);
    if (!HiloEn || (m_mem.v && m_mem.lw))
      chk("MEM_lo_data", MEM_lo_data, HiloEn ? m_mem.lo : 32'd0);
    chk("wb_rdc", wb_rdc, m_wb.rd);
    chk("wb_rd_wena", wb_rd_wena, writes_rd(m_wb));
    chk("wb_hi_wena", wb_hi_wena, HiloEn && m_wb.v && m_wb.hw);
    chk("wb_lo_wena", wb_lo_wena, HiloEn && m_wb.v && m_wb.lw);
    if (writes_rd(m_wb)) chk("wb_rd_data", wb_rd_data, m_wb.res);
    if (!HiloEn || (m_wb.v && m_wb.hw))
      chk("wb_hi_data", wb_hi_data, HiloEn ? m_wb.hi : 32'd0);
    if (!HiloEn || (m_wb.v && m_wb.lw))
      chk("wb_lo_data", wb_lo_data, HiloEn ? m_wb.lo : 32'd0);
    chk("stall_cnt", stall_cnt, m_cnt);
  endtask

  // Called just after a negedge with inputs set; returns just after the next negedge
  task automatic tick();
    #1 check_model();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic set_id(input bit v, input bit [5:0] op, input bit [5:0] func,
                        input bit [4:0] rd, input bit rw, input bit hw, input bit lw);
    id_valid   = v;
    id_op      = op;
    id_func    = func;
    id_rdc     = rd;
    id_rd_wena = rw;
    id_hi_wena = hw;
    id_lo_wena = lw;
  endtask

  task automatic rand_cycle();
    bit [5:0] op;
    case ($urandom_range(0, 8))
      0: op = 6'h00;
      1: op = 6'h08;
      2: op = 6'h23;
      3: op = 6'h21;
      4: op = 6'h25;
      5: op = 6'h20;
      6: op = 6'h24;
      7: op = 6'h2b;
      default: op = 6'($urandom);
    endcase
    set_id($urandom_range(0, 3) != 0, op, 6'($urandom), 5'($urandom_range(0, 7)),
           1'($urandom), 1'($urandom), 1'($urandom));
    stall         = ($urandom_range(0, 4) == 0);
    flush         = ($urandom_range(0, 9) == 0);
    ex_alu_data   = $urandom;
    ex_hi_in      = $urandom;
    ex_lo_in      = $urandom;
    mem_load_data = $urandom;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0);
    ex_alu_data   = '0;
    ex_hi_in      = '0;
    ex_lo_in      = '0;
    mem_load_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst EX_rd_wena", EX_rd_wena, 0);
    chk("rst MEM_rd_wena", MEM_rd_wena, 0);
    chk("rst wb_rd_wena", wb_rd_wena, 0);
    chk("rst stall_cnt", stall_cnt, 0);
    chk("rst MEM_rd_data", MEM_rd_data, 0);
    chk("rst wb_rd_data", wb_rd_data, 0);
    rst_n = 1'b1;

    // ALU propagation: ADD rd=5
    set_id(1, 6'h00, 6'h20, 5, 1, 0, 0);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0);
    ex_alu_data = 32'h1234;
    chk("alu EX_rdc", EX_rdc, 5);
    chk("alu EX_rd_wena", EX_rd_wena, 1);
    tick();
    ex_alu_data = 32'h0;
    chk("alu MEM_rd_data", MEM_rd_data, 32'h1234);
    chk("alu MEM_rd_wena", MEM_rd_wena, 1);
    tick();
    chk("alu wb_rd_data", wb_rd_data, 32'h1234);
    chk("alu wb_rd_wena", wb_rd_wena, 1);
    chk("alu wb_rdc", wb_rdc, 5);

    // Load substitution: LW rd=8
    set_id(1, 6'h23, 6'h00, 8, 1, 0, 0);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0);
    tick();
    mem_load_data = 32'hDEADBEEF;
    #1 chk("ld MEM_rd_data", MEM_rd_data, 32'hDEADBEEF);
    tick();
    mem_load_data = 32'h0;
    chk("ld wb_rd_data", wb_rd_data, 32'hDEADBEEF);
    chk("ld wb_rdc", wb_rdc, 8);

    // Two stall bubbles behind LW rd=8, ADD rd=9 held in ID
    set_id(1, 6'h23, 6'h00, 8, 1, 0, 0);
    tick();
    set_id(1, 6'h00, 6'h20, 9, 1, 0, 0);
    stall = 1'b1;
    tick();
    chk("stl1 EX_rd_wena", EX_rd_wena, 0);
    chk("stl1 MEM_rdc", MEM_rdc, 8);
    chk("stl1 MEM_rd_wena", MEM_rd_wena, 1);
    chk("stl1 stall_cnt", stall_cnt, 1);
    tick();
    chk("stl2 EX_rd_wena", EX_rd_wena, 0);
    chk("stl2 MEM_rd_wena", MEM_rd_wena, 0);
    chk("stl2 wb_rdc", wb_rdc, 8);
    chk("stl2 wb_rd_wena", wb_rd_wena, 1);
    chk("stl2 stall_cnt", stall_cnt, 2);
    stall = 1'b0;
    tick();
    chk("stl3 EX_rdc", EX_rdc, 9);
    chk("stl3 EX_rd_wena", EX_rd_wena, 1);
    set_id(0, 0, 0, 0, 0, 0, 0);
    repeat (2) tick();

    // $0 suppression: ADDI rd=0
    set_id(1, 6'h08, 6'h00, 0, 1, 0, 0);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0);
    chk("r0 EX_rd_wena", EX_rd_wena, 0);
    tick();
    chk("r0 MEM_rd_wena", MEM_rd_wena, 0);
    tick();
    chk("r0 wb_rd_wena", wb_rd_wena, 0);

    // Flush beats stall: MULT in MEM, ADD rd=4 in EX
    set_id(1, 6'h00, 6'h18, 0, 0, 1, 1);
    ex_hi_in = 32'hAAAA;
    ex_lo_in = 32'h5555;
    tick();
    set_id(1, 6'h00, 6'h20, 4, 1, 0, 0);
    tick();
    chk("fl0 MEM_hi_wena", MEM_hi_wena, HiloEn);
    set_id(1, 6'h00, 6'h20, 6, 1, 0, 0);
    flush = 1'b1;
    stall = 1'b1;
    tick();
    chk("fl1 EX_rd_wena", EX_rd_wena, 0);
    chk("fl1 EX_rdc", EX_rdc, 0);
    chk("fl1 MEM_rd_wena", MEM_rd_wena, 0);
    chk("fl1 MEM_rdc", MEM_rdc, 0);
    chk("fl1 MEM_hi_wena", MEM_hi_wena, 0);
    chk("fl1 wb_hi_wena", wb_hi_wena, HiloEn);
    chk("fl1 stall_cnt", stall_cnt, 2);
    flush = 1'b0;
    stall = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("fl2 wb_rd_wena", wb_rd_wena, 0);

    // Randomized traffic with an asynchronous reset in the middle
    for (int i = 0; i < 1500; i++) rand_cycle();
    #2 rst_n = 1'b0;
    #1;
    chk("mrst EX_rd_wena", EX_rd_wena, 0);
    chk("mrst MEM_rd_wena", MEM_rd_wena, 0);
    chk("mrst wb_rd_wena", wb_rd_wena, 0);
    chk("mrst stall_cnt", stall_cnt, 0);
    chk("mrst MEM_rd_data", MEM_rd_data, 0);
    model_reset();
    check_model();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 1500; i++) rand_cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/result_bus_pipe.md
# result_bus_pipe

Producer side of the hazard bus consumed by the forwarding unit. It tracks the destination descriptors of the instructions in EX, MEM and WB and publishes the `EX_*` and `MEM_*` signal sets that the forwarder compares against ID-stage source registers. It accepts the forwarder's stall as a bubble request and substitutes load data into the MEM result. It also drives the register-file and HI/LO write port from WB.

## Interface
Parameters:
- `DW`, 32, data width.
- `RW`, 5, register index width.

Ports:
- `clk`  in  1  pipeline clock; all state updates on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  load-use stall from the forwarder; inserts a bubble into EX.
- `flush`  in  1  kills the instructions in ID→EX and EX→MEM (taken branch/exception).
- `id_valid`  in  1  ID holds a real instruction.
- `id_op`, `id_func`  in  6 each  ID instruction opcode/function.
- `id_rdc`  in  RW  ID destination register.
- `id_rd_wena`, `id_hi_wena`, `id_lo_wena`  in  1 each  ID write enables.
- `ex_alu_data`, `ex_hi_in`, `ex_lo_in`  in  DW each  combinational EX results for the instruction now in EX.
- `mem_load_data`  in  DW  data-memory load result (already extended) for the instruction now in MEM.
- `EX_op`, `EX_func`  out  6 each  EX instruction opcode/function.
- `EX_rdc`  out  RW  EX destination register.
- `EX_rd_wena`, `EX_hi_wena`, `EX_lo_wena`  out  1 each  EX write enables.
- `EX_rd_data`, `EX_hi_data`, `EX_lo_data`  out  DW each  EX result data.
- `MEM_rdc`  out  RW  MEM destination register.
- `MEM_rd_wena`, `MEM_hi_wena`, `MEM_lo_wena`  out  1 each  MEM write enables.
- `MEM_rd_data`, `MEM_hi_data`, `MEM_lo_data`  out  DW each  MEM result data.
- `wb_rdc`, `wb_rd_wena`, `wb_rd_data`, `wb_hi_wena`, `wb_hi_data`, `wb_lo_wena`, `wb_lo_data`  out  register-file and HI/LO write port.
- `stall_cnt`  out  16  saturating count of bubbles inserted.

## Operation
- Three descriptor registers: EX, MEM and WB. Each holds valid, op, func, rdc, the three write enables and an `is_load` flag. MEM and WB also hold data.
- `is_load` is set for op ∈ {`LW_op`, `LH_op`, `LHU_op`, `LB_op`, `LBU_op`} from `MIPS.vh`.
- Every `EX_*`/`MEM_*` write enable is ANDed with that stage's valid bit.
- `rd_wena` is forced to 0 whenever rdc==0, so $0 is never forwarded or written.
- `EX_rd_data`, `EX_hi_data` and `EX_lo_data` are combinational pass-throughs of `ex_alu_data`, `ex_hi_in` and `ex_lo_in`.
- `MEM_rd_data` = MEM.is_load ? `mem_load_data` : registered ALU value. This value is combinational on `mem_load_data`.
- Per posedge, highest priority first:
  - `flush`: EX←bubble, MEM←bubble, WB←old MEM.
  - `stall`: EX←bubble, MEM←old EX, WB←old MEM. The ID instruction is held upstream. `stall_cnt` increments, saturating at 0xFFFF.
  - Otherwise: EX←ID (valid = `id_valid`), MEM←EX (latching `ex_*` data), WB←MEM (latching the selected `MEM_rd_data`).
- A bubble is all-zero: valid=0, op=0, func=0, rdc=0, all enables 0.
- `flush` and `stall` asserted together: `flush` wins and `stall_cnt` does not increment.
- Consecutive `stall` cycles each insert one bubble.

## Timing
- Reset (rst_n=0, asynchronous): every descriptor is a bubble, all registered data is 0 and `stall_cnt`=0.
  - `MEM_rd_data` and `wb_*` outputs are therefore 0.
  - `EX_*_data` outputs still follow their inputs.
- Reset takes effect mid-operation immediately, without a clock edge.
- Latency: an ID instruction latched at edge N appears on `EX_*` after N, on `MEM_*` after N+1 and on `wb_*` after N+2.
- All registered outputs are stable from posedge to posedge, so the forwarder's negedge sample is valid.
- The forwarder's `stall` changes on negedge and is sampled here at the following posedge.

## Configuration
- `HILO_TRACK_EN` defined: HI/LO enables and data are carried through EX/MEM/WB as described.
- Not defined:
  - `EX_hi_wena`, `EX_lo_wena`, `MEM_hi_wena`, `MEM_lo_wena`, `wb_hi_wena` and `wb_lo_wena` are tied 0.
  - All HI/LO data outputs are tied 0 and the HI/LO registers are removed.
  - `id_hi_wena`, `id_lo_wena`, `ex_hi_in` and `ex_lo_in` are ignored.

## Test plan
- **Reset values:** rst_n=0 mid-stream → all enables and `stall_cnt` are 0 within the same cycle, and `MEM_rd_data`=0.
- **ALU propagation:** ADD rd=5 with `ex_alu_data`=0x1234 → `EX_rdc`=5 and `EX_rd_wena`=1 after edge 1; `MEM_rd_data`=0x1234 after edge 2; `wb_rd_data`=0x1234 with `wb_rd_wena`=1 after edge 3.
- **Load substitution:** LW rd=8 with `mem_load_data`=0xDEADBEEF in MEM → `MEM_rd_data`=0xDEADBEEF and `wb_rd_data`=0xDEADBEEF on the next edge.
- **Stall bubble:** `stall`=1 for 2 edges behind LW rd=8 → `EX_rd_wena`=0 for those 2 cycles, LW advances to MEM and then WB, and `stall_cnt`=2.
- **$0 suppression:** ADDI rd=0 → `EX_rd_wena`, `MEM_rd_wena` and `wb_rd_wena` remain 0 throughout.
- **Flush priority:** `flush`=1 and `stall`=1 on the same edge with valid instructions in EX and MEM → EX and MEM become bubbles, WB receives the old MEM contents, and `stall_cnt` is unchanged. With `HILO_TRACK_EN`, a MULT in MEM shows `MEM_hi_wena`=0 after the flush.
